// File: rtl/adc_pkg.sv
// Shared types and constant helpers for the multi-channel SPI ADC front end.
// Holds the frame-state encoding and the width/frame-length helper functions.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } adc_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic int frame_bits(input int nch, input int skip_bits,
                                    input int data_w, input int tail_bits);
    return nch * (skip_bits + data_w) + tail_bits;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Enabled SCK divider: CLK_DIV cycles low then CLK_DIV cycles high.
// The rise/fall strobes flag the clk edge on which SCK will toggle.
module spi_clk_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_sck,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sck;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(CLK_DIV - 1));

  // Dropping the enable parks SCK low with the phase counter cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_sck <= ~r_sck;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sck  = r_sck;
  assign o_rise = i_en && w_wrap && !r_sck;
  assign o_fall = i_en && w_wrap && r_sck;

endmodule

// File: rtl/adc_spi_multi.sv
// SPI reader for a multi-channel serial ADC: pulses CONV, shifts NCH samples
// in MSB first and publishes the truncated samples together on DONE.
module adc_spi_multi
  import adc_pkg::*;
#(
  parameter int DATA_W    = 14,
  parameter int OUT_W     = 8,
  parameter int NCH       = 2,
  parameter int SKIP_BITS = 2,
  parameter int TAIL_BITS = 2,
  parameter int CLK_DIV   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 GO_ADC,
  input  logic                 CONT,
  input  logic                 SPI_MISO,
  output logic                 DONE_ADC,
  output logic                 BUSY,
  output logic                 OVERRUN,
  output logic                 ADC_CONV,
  output logic                 SPI_CLK_ADC,
  output logic [NCH*OUT_W-1:0] ADC
);

  localparam int FRAME_BITS = frame_bits(NCH, SKIP_BITS, DATA_W, TAIL_BITS);
  localparam int BIT_W      = clog2(FRAME_BITS + 1);
  localparam int CONV_CYC   = 2 * CLK_DIV;
  localparam int CONV_W     = clog2(CONV_CYC + 1);

  adc_state_t           r_state;
  adc_state_t           w_next;
  logic [BIT_W-1:0]     r_bit;
  logic [CONV_W-1:0]    r_conv_cnt;
  logic                 r_ovr;
  logic [NCH*OUT_W-1:0] r_adc;
  logic [NCH*OUT_W-1:0] w_samples;
  logic                 w_shift_en;
  logic                 w_sck;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_last;
  logic                 w_conv_end;

  assign w_shift_en = (r_state == SHIFT);
  assign w_last     = w_fall && (r_bit == BIT_W'(FRAME_BITS - 1));
  assign w_conv_end = (r_conv_cnt == CONV_W'(CONV_CYC - 1));

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_shift_en),
    .o_sck (w_sck),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (GO_ADC || CONT) w_next = CONV;
      CONV:    if (w_conv_end) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = CONT ? CONV : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The bit index advances on SCK falls so it is stable across each sampling rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_conv_cnt <= '0;
      r_bit      <= '0;
      r_ovr      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ovr      <= GO_ADC && (r_state != IDLE);
      r_conv_cnt <= (r_state == CONV) ? r_conv_cnt + 1'b1 : '0;
      if (r_state != SHIFT) begin
        r_bit <= '0;
      end else if (w_fall) begin
        r_bit <= r_bit + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam int WIN_LO = k * (SKIP_BITS + DATA_W) + SKIP_BITS;
    localparam int WIN_HI = WIN_LO + DATA_W;

    logic [DATA_W-1:0] r_sr;
    logic              w_in_win;

    assign w_in_win = (r_bit >= BIT_W'(WIN_LO)) && (r_bit < BIT_W'(WIN_HI));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sr <= '0;
      end else if (w_rise && w_in_win) begin
        r_sr <= (r_sr << 1) | DATA_W'(SPI_MISO);
      end
    end

    assign w_samples[k*OUT_W +: OUT_W] = r_sr[DATA_W-1 -: OUT_W];
  end

  // All channels are captured together on entry to DONE, so partial frames never show.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_adc <= '0;
    end else if (w_last) begin
      r_adc <= w_samples;
    end
  end

  assign BUSY        = (r_state != IDLE);
  assign ADC_CONV    = (r_state == CONV);
  assign DONE_ADC    = (r_state == DONE);
  assign SPI_CLK_ADC = w_sck;
  assign OVERRUN     = r_ovr;
  assign ADC         = r_adc;

endmodule

// File: tb/tb_adc_spi_multi.sv
// Directed bench for adc_spi_multi: default 2x14->8 instance plus a
// 3x12->12 instance with a slower SCK, each fed by a bit-stream ADC model.
module tb_adc_spi_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        goA = 1'b0;
  logic        contA = 1'b0;
  logic        misoA = 1'b0;
  logic        goB = 1'b0;
  logic        contB = 1'b0;
  logic        misoB = 1'b0;
  logic        doneA, busyA, ovrA, convA, sckA;
  logic        doneB, busyB, ovrB, convB, sckB;
  logic [15:0] adcA;
  logic [35:0] adcB;

  logic streamA [0:255];
  logic streamB [0:255];
  int   risesA = 0;
  int   risesB = 0;
  logic prevSckA = 1'b0;
  logic prevSckB = 1'b0;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [13:0] ch0;
    logic [13:0] ch1;
    logic        padVal;
    logic [15:0] expAdc;
  } vec_t;

  vec_t vecs [4];

  adc_spi_multi dut (
    .clk        (clk),
    .reset      (reset),
    .GO_ADC     (goA),
    .CONT       (contA),
    .SPI_MISO   (misoA),
    .DONE_ADC   (doneA),
    .BUSY       (busyA),
    .OVERRUN    (ovrA),
    .ADC_CONV   (convA),
    .SPI_CLK_ADC(sckA),
    .ADC        (adcA)
  );

  adc_spi_multi #(
    .DATA_W (12),
    .OUT_W  (12),
    .NCH    (3),
    .CLK_DIV(3)
  ) dut3 (
    .clk        (clk),
    .reset      (reset),
    .GO_ADC     (goB),
    .CONT       (contB),
    .SPI_MISO   (misoB),
    .DONE_ADC   (doneB),
    .BUSY       (busyB),
    .OVERRUN    (ovrB),
    .ADC_CONV   (convB),
    .SPI_CLK_ADC(sckB),
    .ADC        (adcB)
  );

  always #5 clk = ~clk;

  // ADC models: present stream bit n until the n-th SCK rise has been seen.
  always @(negedge clk) begin
    if (convA) risesA = 0;
    else if (sckA && !prevSckA) risesA++;
    prevSckA = sckA;
    misoA = (risesA < 256) ? streamA[risesA] : 1'b0;
  end

  always @(negedge clk) begin
    if (convB) risesB = 0;
    else if (sckB && !prevSckB) risesB++;
    prevSckB = sckB;
    misoB = (risesB < 256) ? streamB[risesB] : 1'b0;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic fillStreamA(input logic [13:0] c0, input logic [13:0] c1,
                             input logic padVal);
    for (int i = 0; i < 256; i++) streamA[i] = padVal;
    for (int j = 0; j < 14; j++) begin
      streamA[2 + j]  = c0[13 - j];
      streamA[18 + j] = c1[13 - j];
    end
  endtask

  task automatic fillStreamB(input logic [11:0] c0, input logic [11:0] c1,
                             input logic [11:0] c2);
    for (int i = 0; i < 256; i++) streamB[i] = 1'b0;
    for (int j = 0; j < 12; j++) begin
      streamB[2 + j]  = c0[11 - j];
      streamB[16 + j] = c1[11 - j];
      streamB[30 + j] = c2[11 - j];
    end
  endtask

  // One GO-started frame on the default instance; k counts cycles after the GO edge.
  task automatic applyStimulus(input bit rePulse, output int doneAt, output int doneCnt,
                               output int convCnt, output int ovrAt, output int ovrCnt,
                               output logic [15:0] midAdc, output logic [15:0] doneAdc);
    doneAt = -1;
    doneCnt = 0;
    convCnt = 0;
    ovrAt = -1;
    ovrCnt = 0;
    midAdc = '0;
    doneAdc = '0;
    @(negedge clk);
    goA = 1'b1;
    @(posedge clk);
    #1 goA = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (doneA) begin
        doneCnt++;
        if (doneAt < 0) doneAt = k;
        doneAdc = adcA;
      end
      if (convA) convCnt++;
      if (ovrA) begin
        ovrCnt++;
        if (ovrAt < 0) ovrAt = k;
      end
      if (k == 40) midAdc = adcA;
      goA = rePulse && (k == 20);
    end
  endtask

  initial begin
    int          doneAt, doneCnt, convCnt, ovrAt, ovrCnt, bad, nDone;
    logic [15:0] midAdc, doneAdc, prevAdc, lastAdc;
    logic        busyBefore, busyLater;
    int          doneTimes [8];

    vecs[0] = '{14'h2A5C, 14'h1FFF, 1'b1, 16'h7FA9};
    vecs[1] = '{14'h3FFF, 14'h0000, 1'b0, 16'h00FF};
    vecs[2] = '{14'h0000, 14'h3FFF, 1'b1, 16'hFF00};
    vecs[3] = '{14'h1234, 14'h2ABC, 1'b0, 16'hAA48};
    fillStreamA(14'h0, 14'h0, 1'b0);
    fillStreamB(12'h0, 12'h0, 12'h0);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("resetOutputsA", {42'd0, adcA, busyA, convA, sckA, doneA, ovrA}, 64'd0);
    checkOutput("resetOutputsB", {23'd0, adcB, busyB, convB, sckB, doneB, ovrB}, 64'd0);

    prevAdc = '0;
    for (int v = 0; v < 4; v++) begin
      fillStreamA(vecs[v].ch0, vecs[v].ch1, vecs[v].padVal);
      applyStimulus(1'b0, doneAt, doneCnt, convCnt, ovrAt, ovrCnt, midAdc, doneAdc);
      checkOutput($sformatf("vec%0d doneAt", v), 64'(doneAt), 64'd71);
      checkOutput($sformatf("vec%0d doneCount", v), 64'(doneCnt), 64'd1);
      checkOutput($sformatf("vec%0d convCycles", v), 64'(convCnt), 64'd2);
      checkOutput($sformatf("vec%0d sckRises", v), 64'(risesA), 64'd34);
      checkOutput($sformatf("vec%0d adc", v), 64'(doneAdc), 64'(vecs[v].expAdc));
      checkOutput($sformatf("vec%0d adcHeldMidFrame", v), 64'(midAdc), 64'(prevAdc));
      checkOutput($sformatf("vec%0d noOverrun", v), 64'(ovrCnt), 64'd0);
      prevAdc = vecs[v].expAdc;
    end

    // GO re-pulsed while busy must flag OVERRUN and leave the frame untouched.
    fillStreamA(14'h2A5C, 14'h1FFF, 1'b1);
    applyStimulus(1'b1, doneAt, doneCnt, convCnt, ovrAt, ovrCnt, midAdc, doneAdc);
    checkOutput("overrun at", 64'(ovrAt), 64'd21);
    checkOutput("overrun count", 64'(ovrCnt), 64'd1);
    checkOutput("overrun doneAt", 64'(doneAt), 64'd71);
    checkOutput("overrun doneCount", 64'(doneCnt), 64'd1);
    checkOutput("overrun adc", 64'(doneAdc), 64'h7FA9);

    // Reset in the middle of a frame clears everything at once.
    fillStreamA(14'h3FFF, 14'h3FFF, 1'b1);
    @(negedge clk);
    goA = 1'b1;
    @(posedge clk);
    #1 goA = 1'b0;
    repeat (40) @(negedge clk);
    busyBefore = busyA;
    reset = 1'b1;
    #1;
    checkOutput("busy before reset", 64'(busyBefore), 64'd1);
    checkOutput("async reset outputs", {42'd0, adcA, busyA, convA, sckA, doneA, ovrA}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (busyA || convA || sckA || doneA || ovrA || (adcA != 16'h0)) bad++;
    end
    checkOutput("idle after reset", 64'(bad), 64'd0);

    // Free-running mode with MISO stuck high, then CONT dropped mid-frame.
    fillStreamA(14'h3FFF, 14'h3FFF, 1'b1);
    nDone = 0;
    lastAdc = '0;
    busyLater = 1'b1;
    @(negedge clk);
    contA = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (doneA) begin
        if (nDone < 8) doneTimes[nDone] = k;
        nDone++;
        lastAdc = adcA;
      end
      if (k == 290) busyLater = busyA;
      if (k == 250) contA = 1'b0;
    end
    checkOutput("cont done count", 64'(nDone), 64'd4);
    checkOutput("cont done0", 64'(doneTimes[0]), 64'd71);
    checkOutput("cont spacing1", 64'(doneTimes[1] - doneTimes[0]), 64'd71);
    checkOutput("cont spacing2", 64'(doneTimes[2] - doneTimes[1]), 64'd71);
    checkOutput("cont final done", 64'(doneTimes[3]), 64'd284);
    checkOutput("cont adc", 64'(lastAdc), 64'hFFFF);
    checkOutput("cont busy after stop", 64'(busyLater), 64'd0);
    checkOutput("cont busy at end", 64'(busyA), 64'd0);

    // Three 12-bit channels with a divide-by-3 SCK.
    fillStreamB(12'h123, 12'h456, 12'h789);
    doneAt = -1;
    doneCnt = 0;
    convCnt = 0;
    @(negedge clk);
    goB = 1'b1;
    @(posedge clk);
    #1 goB = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (doneB) begin
        doneCnt++;
        if (doneAt < 0) doneAt = k;
      end
      if (convB) convCnt++;
    end
    checkOutput("nch3 doneAt", 64'(doneAt), 64'd271);
    checkOutput("nch3 doneCount", 64'(doneCnt), 64'd1);
    checkOutput("nch3 convCycles", 64'(convCnt), 64'd6);
    checkOutput("nch3 sckRises", 64'(risesB), 64'd44);
    checkOutput("nch3 adc", 64'(adcB), 64'h789456123);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
